// File: rtl/master_arb_tx.sv
`default_nettype none
// ============================================================================
//  Module   : master_arb_tx
//  Brief    : Bus-request master that talks to an arbiter over a single serial
//             line. Sends a request frame (111 + 2-bit slave id), waits for the
//             grant level, answers with an accept (101) or NAK (110) frame,
//             holds the bus in COM and closes with a single-bit end marker.
//  Options  : MASTER_ARB_TX_TIMEOUT_EN - abandons WAIT_GNT after
//             GRANT_TIMEOUT cycles without a grant and pulses timeout_err.
//  Revision : 1.0 - initial release
// ============================================================================
module master_arb_tx #(
  parameter int GRANT_TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       req,
  input  logic [1:0] slave_id,
  input  logic       done,
  input  logic       abort,
  input  logic       arb_in,
  output logic       arb_out,
  output logic       busy,
  output logic       granted,
  output logic       timeout_err
);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_HDR      = 3'd1,
    ST_ID       = 3'd2,
    ST_WAIT_GNT = 3'd3,
    ST_ACK      = 3'd4,
    ST_COM      = 3'd5,
    ST_END      = 3'd6,
    ST_RELEASE  = 3'd7
  } state_t;

  // Last bit index of each multi-bit frame
  localparam logic [1:0] HDR_LAST = 2'd2;
  localparam logic [1:0] ID_LAST  = 2'd1;
  localparam logic [1:0] ACK_LAST = 2'd2;

  state_t     state;
  state_t     state_nxt;
  logic [1:0] bit_cnt;
  logic [1:0] bit_cnt_nxt;
  logic [1:0] id_q;
  logic [1:0] id_nxt;
  logic       abort_pend;
  logic       abort_pend_nxt;
  logic       arb_out_nxt;
  logic       tmo_hit;

`ifdef MASTER_ARB_TX_TIMEOUT_EN
  localparam int TMO_W = (GRANT_TIMEOUT > 1) ? $clog2(GRANT_TIMEOUT) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(GRANT_TIMEOUT - 1);

  logic [TMO_W-1:0] tmo_cnt;
  logic             tmo_err_q;

  // Count consecutive grant-less WAIT_GNT cycles; zero on entry
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tmo_cnt <= '0;
    end else if (state == ST_WAIT_GNT && state_nxt == ST_WAIT_GNT) begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end else begin
      tmo_cnt <= '0;
    end
  end

  // A grant sampled on the expiry cycle takes priority over the timeout
  assign tmo_hit = (state == ST_WAIT_GNT) && !arb_in && (tmo_cnt == TMO_LAST);

  // Registered one-cycle error pulse, coincident with the return to IDLE
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tmo_err_q <= 1'b0;
    end else begin
      tmo_err_q <= tmo_hit;
    end
  end

  assign timeout_err = tmo_err_q;
`else
  assign tmo_hit     = 1'b0;
  assign timeout_err = 1'b0;
`endif

  // Next-state, captured id, abort tracking and next serial bit
  always_comb begin
    state_nxt      = state;
    id_nxt         = id_q;
    abort_pend_nxt = abort_pend;
    bit_cnt_nxt    = 2'd0;
    arb_out_nxt    = 1'b0;

    case (state)
      ST_IDLE: begin
        if (req && !arb_in) begin
          state_nxt = ST_HDR;
          id_nxt    = slave_id;
        end
      end
      ST_HDR: begin
        if (abort) abort_pend_nxt = 1'b1;
        if (bit_cnt == HDR_LAST) state_nxt = ST_ID;
      end
      ST_ID: begin
        if (abort) abort_pend_nxt = 1'b1;
        if (bit_cnt == ID_LAST) state_nxt = ST_WAIT_GNT;
      end
      ST_WAIT_GNT: begin
        if (abort) abort_pend_nxt = 1'b1;
        if (arb_in) begin
          state_nxt = ST_ACK;
        end else if (tmo_hit) begin
          state_nxt = ST_IDLE;
        end
      end
      ST_ACK: begin
        if (bit_cnt == ACK_LAST) state_nxt = abort_pend ? ST_RELEASE : ST_COM;
      end
      ST_COM: begin
        // abort while holding the bus simply ends the transaction
        if (done || abort) state_nxt = ST_END;
      end
      ST_END: begin
        state_nxt = ST_RELEASE;
      end
      ST_RELEASE: begin
        if (!arb_in) state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase

    if (state_nxt == ST_IDLE) abort_pend_nxt = 1'b0;

    // Bit index restarts at zero whenever a new state is entered
    if (state_nxt == state &&
        (state == ST_HDR || state == ST_ID || state == ST_ACK)) begin
      bit_cnt_nxt = bit_cnt + 2'd1;
    end

    // The serial bit is derived from the state being entered so that the
    // registered line shows each state's bit during that state's cycle
    case (state_nxt)
      ST_HDR: arb_out_nxt = 1'b1;
      ST_ID:  arb_out_nxt = (bit_cnt_nxt == 2'd0) ? id_nxt[1] : id_nxt[0];
      ST_ACK: begin
        case (bit_cnt_nxt)
          2'd0:    arb_out_nxt = 1'b1;
          2'd1:    arb_out_nxt = abort_pend_nxt;
          default: arb_out_nxt = !abort_pend_nxt;
        endcase
      end
      ST_END:  arb_out_nxt = 1'b1;
      default: arb_out_nxt = 1'b0;
    endcase
  end

  // State, counters and the registered serial line
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= ST_IDLE;
      bit_cnt    <= 2'd0;
      id_q       <= 2'd0;
      abort_pend <= 1'b0;
      arb_out    <= 1'b0;
    end else begin
      state      <= state_nxt;
      bit_cnt    <= bit_cnt_nxt;
      id_q       <= id_nxt;
      abort_pend <= abort_pend_nxt;
      arb_out    <= arb_out_nxt;
    end
  end

  assign busy    = (state != ST_IDLE);
  assign granted = (state == ST_COM);

endmodule
`default_nettype wire

// File: doc/master_arb_tx.md
MASTER_ARB_TX -- requirements
Module: master_arb_tx

Interface
REQ-001 SHALL have parameter GRANT_TIMEOUT, default 255, meaning max cycles spent in WAIT_GNT before abandoning a request (used only with MASTER_ARB_TX_TIMEOUT_EN).
REQ-002 SHALL have ports:
  - clk  input  1  system clock, all logic on rising edge.
  - rstn  input  1  reset, asynchronous, active-low.
  - req  input  1  user request for the bus; sampled in IDLE.
  - slave_id  input  2  target slave id; captured with req.
  - done  input  1  user pulse ending the transaction.
  - abort  input  1  user pulse cancelling the pending or active request.
  - arb_in  input  1  grant line from arbiter (level, high = bus granted).
  - arb_out  output  1  serial line to arbiter, registered.
  - busy  output  1  high in every state except IDLE.
  - granted  output  1  high only in COM; user may drive the bus.
  - timeout_err  output  1  one-cycle pulse on grant timeout.

Function
REQ-003 SHALL implement states IDLE, HDR, ID, WAIT_GNT, ACK, COM, END, RELEASE.
REQ-004 IDLE: arb_out=0; when req=1 and arb_in=0, SHALL capture slave_id and go to HDR; req ignored while arb_in=1.
REQ-005 HDR SHALL drive arb_out=1 for exactly 3 cycles; first 1 appears the cycle after req is sampled.
REQ-006 ID SHALL drive captured slave_id[1], then slave_id[0], one cycle each, then go to WAIT_GNT.
REQ-007 Request frame latency: req sampled at edge k -> arb_out = 1,1,1,id[1],id[0] in cycles k+1..k+5, 0 from k+6.
REQ-008 WAIT_GNT SHALL hold arb_out=0 until arb_in=1, then go to ACK.
REQ-009 ACK SHALL send 3 bits: 1,0,1 (accept) normally; 1,1,0 (NAK) if abort_pending is set.
REQ-010 After accept frame SHALL enter COM; after NAK frame SHALL enter RELEASE.
REQ-011 COM: arb_out=0, granted=1; on done=1 SHALL go to END.
REQ-012 END SHALL drive arb_out=1 for exactly one cycle (forming 0->1 end marker), then arb_out=0, go to RELEASE.
REQ-013 RELEASE: arb_out=0; SHALL return to IDLE the cycle after arb_in is observed 0.
REQ-014 abort during HDR, ID, or WAIT_GNT SHALL set abort_pending; frames are never truncated.
REQ-015 abort_pending SHALL clear on entry to IDLE.
REQ-016 abort during COM SHALL be treated exactly as done; done and abort together behave as done.
REQ-017 abort/done outside their stated states SHALL be ignored (done ignored everywhere except COM).
REQ-018 granted SHALL deassert in the same cycle END is entered; busy SHALL deassert on entry to IDLE.
REQ-019 Bit counter SHALL be 2 bits, reset to 0 on each state entry.

Reset
REQ-020 On rstn=0 all outputs SHALL go to 0 immediately; state=IDLE, abort_pending=0, counters=0.
REQ-021 Reset mid-frame SHALL drop arb_out to 0 without completing the frame; first post-reset cycle is IDLE.

Configuration
REQ-022 Macro MASTER_ARB_TX_TIMEOUT_EN defined: a cycle counter SHALL run in WAIT_GNT; if arb_in is still 0 after GRANT_TIMEOUT cycles, timeout_err SHALL pulse for one cycle and the state SHALL go to IDLE.
REQ-023 Grant arriving in the same cycle as timeout SHALL win (go to ACK, no timeout_err).
REQ-024 Macro undefined: no counter, timeout_err tied 0, WAIT_GNT waits indefinitely.

Verification
REQ-025 req=1, slave_id=2'b10 in IDLE -> arb_out 1,1,1,1,0 in cycles k+1..k+5, busy=1 from k+1.
REQ-026 arb_in=1 during WAIT_GNT -> arb_out 1,0,1, then granted=1; done pulse -> arb_out single 1, granted=0; arb_in=0 -> IDLE, busy=0.
REQ-027 abort during ID, later arb_in=1 -> arb_out 1,1,0, granted never 1, IDLE after arb_in=0.
REQ-028 MASTER_ARB_TX_TIMEOUT_EN, GRANT_TIMEOUT=8, no grant -> timeout_err one-cycle pulse 8 cycles after WAIT_GNT entry, then IDLE; grant on cycle 8 -> ACK, no pulse.
REQ-029 rstn=0 during HDR cycle 2 -> arb_out=0 same cycle; after release, req restarts full 5-bit frame.
REQ-030 req=1 while arb_in=1 in IDLE -> no frame sent until arb_in=0.
